// File: rtl/video_frame_buffer_pkg.sv
// ============================================================================
// video_frame_buffer_pkg : shared digit geometry, FSM states and buffer type
// Rev 1.0
// ============================================================================
`default_nettype none

package video_frame_buffer_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DATA_W     = 8;
    localparam int ADDR_W     = $clog2(NUM_DIGITS);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } fb_state_t;

    typedef logic [NUM_DIGITS-1:0][DATA_W-1:0] digit_array_t;

endpackage

`default_nettype wire

// File: rtl/video_frame_buffer_frame_tick_gen.sv
// ============================================================================
// frame_tick_gen : one-cycle Frame_Tick every REFRESH_DIV clocks
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_tick_gen #(
    parameter int REFRESH_DIV = 50000
) (
    input  logic Clock,
    input  logic Reset_n,
    output logic Frame_Tick
);

    localparam int                CNT_W    = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0]  LAST     = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0]  PRE_LAST = CNT_W'(REFRESH_DIV - 2);

    logic [CNT_W-1:0] count;

    // The pulse is registered one count early so it lines up with count==LAST.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count      <= '0;
            Frame_Tick <= 1'b0;
        end else begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
            Frame_Tick <= (count == PRE_LAST);
        end
    end

endmodule

`default_nettype wire

// File: rtl/video_frame_buffer.sv
// ============================================================================
// video_frame_buffer : double-buffered 8-digit display memory with clear engine
// Rev 1.0
// ============================================================================
`default_nettype none

module video_frame_buffer
    import video_frame_buffer_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Write_Enable,
    input  logic [ADDR_W-1:0] Write_Address,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Swap_Request,
    input  logic              Clear_Request,
    output logic              Busy,
    output logic              Swap_Pending,
    output logic              Frame_Tick,
    output logic [DATA_W-1:0] Video_Data0,
    output logic [DATA_W-1:0] Video_Data1,
    output logic [DATA_W-1:0] Video_Data2,
    output logic [DATA_W-1:0] Video_Data3,
    output logic [DATA_W-1:0] Video_Data4,
    output logic [DATA_W-1:0] Video_Data5,
    output logic [DATA_W-1:0] Video_Data6,
    output logic [DATA_W-1:0] Video_Data7
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_DIGITS - 1);

    fb_state_t         state;
    logic [ADDR_W-1:0] clr_idx;
    digit_array_t      back_buf;
    digit_array_t      front_buf;
    logic              frame_tick;
    logic              do_swap;

    frame_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV)
    ) u_frame_tick_gen (
        .Clock      (Clock),
        .Reset_n    (Reset_n),
        .Frame_Tick (frame_tick)
    );

    assign Frame_Tick = frame_tick;
    assign do_swap    = frame_tick && Swap_Pending && (state == IDLE);

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state        <= IDLE;
            clr_idx      <= '0;
            back_buf     <= '0;
            front_buf    <= '0;
            Busy         <= 1'b0;
            Swap_Pending <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A clear request takes priority over a same-cycle write.
                    if (Clear_Request) begin
                        state   <= CLEAR;
                        clr_idx <= '0;
                        Busy    <= 1'b1;
                    end else if (Write_Enable) begin
                        back_buf[Write_Address] <= Write_Data;
                    end
                end
                CLEAR: begin
                    back_buf[clr_idx] <= '0;
                    clr_idx           <= clr_idx + 1'b1;
                    if (clr_idx == LAST_IDX) begin
                        state <= IDLE;
                        Busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                end
            endcase

            // Copy uses the pre-edge back buffer, so a same-edge write lands only in back.
            if (do_swap) begin
                front_buf <= back_buf;
            end

            if (do_swap) begin
                Swap_Pending <= 1'b0;
            end else if (Swap_Request) begin
                Swap_Pending <= 1'b1;
            end
        end
    end

    assign Video_Data0 = front_buf[0];
    assign Video_Data1 = front_buf[1];
    assign Video_Data2 = front_buf[2];
    assign Video_Data3 = front_buf[3];
    assign Video_Data4 = front_buf[4];
    assign Video_Data5 = front_buf[5];
    assign Video_Data6 = front_buf[6];
    assign Video_Data7 = front_buf[7];

endmodule

`default_nettype wire

// File: tb/tb_video_frame_buffer.sv
// ============================================================================
// tb_video_frame_buffer : directed stimulus checked against a behavioural model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_video_frame_buffer;

    localparam int DIV = 4;

    logic       Clock = 1'b0;
    logic       Reset_n;
    logic       Write_Enable;
    logic [2:0] Write_Address;
    logic [7:0] Write_Data;
    logic       Swap_Request;
    logic       Clear_Request;
    logic       Busy;
    logic       Swap_Pending;
    logic       Frame_Tick;
    logic [7:0] Video_Data0, Video_Data1, Video_Data2, Video_Data3;
    logic [7:0] Video_Data4, Video_Data5, Video_Data6, Video_Data7;
    logic [7:0] vid [8];

    int vectors    = 0;
    int miscompares = 0;
    bit chk_en     = 0;

    // behavioural model state
    logic [7:0] mback  [8];
    logic [7:0] mfront [8];
    int         mcyc;
    int         mclr;
    bit         mpend;

    video_frame_buffer #(.REFRESH_DIV(DIV)) dut (
        .Clock         (Clock),
        .Reset_n       (Reset_n),
        .Write_Enable  (Write_Enable),
        .Write_Address (Write_Address),
        .Write_Data    (Write_Data),
        .Swap_Request  (Swap_Request),
        .Clear_Request (Clear_Request),
        .Busy          (Busy),
        .Swap_Pending  (Swap_Pending),
        .Frame_Tick    (Frame_Tick),
        .Video_Data0   (Video_Data0),
        .Video_Data1   (Video_Data1),
        .Video_Data2   (Video_Data2),
        .Video_Data3   (Video_Data3),
        .Video_Data4   (Video_Data4),
        .Video_Data5   (Video_Data5),
        .Video_Data6   (Video_Data6),
        .Video_Data7   (Video_Data7)
    );

    assign vid[0] = Video_Data0;
    assign vid[1] = Video_Data1;
    assign vid[2] = Video_Data2;
    assign vid[3] = Video_Data3;
    assign vid[4] = Video_Data4;
    assign vid[5] = Video_Data5;
    assign vid[6] = Video_Data6;
    assign vid[7] = Video_Data7;

    always #5 Clock = ~Clock;

    task automatic cmp(input string name, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: tick falls on every DIV-th cycle after reset; clear takes 8 cycles.
    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < 8; i++) begin
                mback[i]  = 8'h00;
                mfront[i] = 8'h00;
            end
            mcyc  = 0;
            mclr  = 0;
            mpend = 0;
        end else begin
            bit tick;
            bit idle;
            bit swap;
            tick = (mcyc % DIV) == DIV - 1;
            idle = (mclr == 0);
            swap = tick && mpend && idle;
            if (swap) begin
                for (int i = 0; i < 8; i++) mfront[i] = mback[i];
            end
            if (idle) begin
                if (Clear_Request) mclr = 8;
                else if (Write_Enable) mback[Write_Address] = Write_Data;
            end else begin
                mback[8 - mclr] = 8'h00;
                mclr--;
            end
            if (swap) mpend = 0;
            else if (Swap_Request) mpend = 1;
            mcyc++;
        end
    end

    always @(negedge Clock) begin
        if (chk_en) begin
            cmp("busy", {7'd0, Busy}, {7'd0, mclr != 0});
            cmp("swap_pending", {7'd0, Swap_Pending}, {7'd0, mpend});
            cmp("frame_tick", {7'd0, Frame_Tick}, {7'd0, (mcyc % DIV) == DIV - 1});
            for (int d = 0; d < 8; d++) cmp($sformatf("video%0d", d), vid[d], mfront[d]);
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic wr(input logic [2:0] a, input logic [7:0] d);
        Write_Enable = 1; Write_Address = a; Write_Data = d;
        step(1);
        Write_Enable = 0;
    endtask

    task automatic pulse_swap();
        Swap_Request = 1;
        step(1);
        Swap_Request = 0;
    endtask

    // Returns at a negedge inside a tick cycle; inputs set now are seen at that tick's edge.
    task automatic wait_tick();
        bit found;
        found = 0;
        for (int i = 0; i < 12 && !found; i++) begin
            if (Frame_Tick === 1'b1) found = 1;
            else step(1);
        end
        if (!found) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_tick: Frame_Tick got 0 expected 1 within bound");
        end
    endtask

    task automatic swap_now();
        pulse_swap();
        wait_tick();
        step(1);
    endtask

    initial begin
        int n;
        Reset_n = 0; Write_Enable = 0; Write_Address = 0; Write_Data = 0;
        Swap_Request = 0; Clear_Request = 0;
        step(3);
        Reset_n = 1;
        chk_en  = 1;

        // reset / idle
        step(10);
        for (int d = 0; d < 8; d++) cmp($sformatf("rst_video%0d", d), vid[d], 8'h00);
        cmp("rst_busy", {7'd0, Busy}, 8'h00);
        cmp("rst_pending", {7'd0, Swap_Pending}, 8'h00);

        // single write then swap
        wr(3, 8'h5A);
        pulse_swap();
        cmp("pending_set", {7'd0, Swap_Pending}, 8'h01);
        wait_tick();
        step(1);
        cmp("swap_v3", Video_Data3, 8'h5A);
        cmp("swap_v0", Video_Data0, 8'h00);
        cmp("swap_pending_drop", {7'd0, Swap_Pending}, 8'h00);

        // fill, clear while writing, swap zeros
        for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h11 * (i + 1)));
        Clear_Request = 1;
        step(1);
        Clear_Request = 0;
        Write_Enable = 1; Write_Address = 2; Write_Data = 8'hFF;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            n++;
            step(1);
        end
        Write_Enable = 0;
        cmp("busy_len", 8'(n), 8'd8);
        swap_now();
        cmp("clr_v3", Video_Data3, 8'h00);
        cmp("clr_v2", Video_Data2, 8'h00);
        cmp("clr_v7", Video_Data7, 8'h00);

        // tick during clear with swap pending: copy deferred
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h77);
        swap_now();
        cmp("fill77_v5", Video_Data5, 8'h77);
        Swap_Request = 1; Clear_Request = 1;
        step(1);
        Swap_Request = 0; Clear_Request = 0;
        n = 0;
        while (Busy === 1'b1 && n < 20) begin
            n++;
            step(1);
        end
        cmp("defer_v0", Video_Data0, 8'h77);
        cmp("defer_pending", {7'd0, Swap_Pending}, 8'h01);
        wait_tick();
        step(1);
        cmp("defer_done_v0", Video_Data0, 8'h00);
        cmp("defer_done_v5", Video_Data5, 8'h00);

        // write on the swap edge
        wr(0, 8'h22);
        pulse_swap();
        wait_tick();
        Write_Enable = 1; Write_Address = 0; Write_Data = 8'hAA;
        step(1);
        Write_Enable = 0;
        cmp("same_edge_v0", Video_Data0, 8'h22);
        swap_now();
        cmp("second_swap_v0", Video_Data0, 8'hAA);

        // async reset mid-clear
        for (int i = 0; i < 8; i++) wr(3'(i), 8'h77);
        swap_now();
        cmp("pre_rst_v7", Video_Data7, 8'h77);
        Clear_Request = 1; Swap_Request = 1;
        step(1);
        Clear_Request = 0; Swap_Request = 0;
        step(4);
        #2 Reset_n = 0;
        #1;
        for (int d = 0; d < 8; d++) cmp($sformatf("async_video%0d", d), vid[d], 8'h00);
        cmp("async_busy", {7'd0, Busy}, 8'h00);
        cmp("async_pending", {7'd0, Swap_Pending}, 8'h00);
        step(2);
        Reset_n = 1;
        step(12);
        cmp("post_rst_busy", {7'd0, Busy}, 8'h00);
        cmp("post_rst_v4", Video_Data4, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
